// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse rate counter block.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF          = 8;
    localparam int unsigned WIN_CYCLES_DEF     = 1000;
    localparam int unsigned REFRACT_CYCLES_DEF = 20;
    localparam int unsigned ONESHOT_DEF        = 0;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned min_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_edge_filter.sv
// Synchronises the raw pulse pin, detects rising edges and enforces a
// refractory lockout so that bounce after a beat is not counted again.
module pulse_edge_filter
    import pulse_pkg::*;
#(
    parameter int unsigned REFRACT_CYCLES = REFRACT_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic pulse_in,
    output logic edge_acc
);

    localparam int unsigned         LOCK_W    = min_bits(REFRACT_CYCLES + 1);
    localparam logic [LOCK_W-1:0]   LOCK_LOAD = LOCK_W'(REFRACT_CYCLES);

    logic              s1, s2, s3;
    logic              edge_raw;
    logic [LOCK_W-1:0] lock;

    // Three-flop chain: s1/s2 resolve metastability, s3 gives the edge reference.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Rising edge is accepted only once the lockout has expired.
    always_comb begin
        edge_raw = s2 & ~s3;
        edge_acc = edge_raw & (lock == '0);
    end

    // Lockout reloads on every accepted edge and counts down to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            lock <= '0;
        end else if (edge_acc) begin
            lock <= LOCK_LOAD;
        end else if (lock != '0) begin
            lock <= lock - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_rate_counter.sv
// Counts filtered pulse edges over fixed windows and publishes a held
// per-window count with a one-cycle valid strobe and a saturation flag.
module pulse_rate_counter
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned WIN_CYCLES     = WIN_CYCLES_DEF,
    parameter int unsigned REFRACT_CYCLES = REFRACT_CYCLES_DEF,
    parameter int unsigned ONESHOT        = ONESHOT_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enb,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] live_q,
    output logic [CNT_W-1:0] rate_q,
    output logic             rate_valid,
    output logic             rate_ovf,
    output logic             busy
);

    localparam int unsigned        WIN_W    = min_bits(WIN_CYCLES);
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    state_t             state, state_nxt;
    logic [WIN_W-1:0]   win_cnt;
    logic               sat;
    logic               edge_acc;
    logic [CNT_W-1:0]   live_inc;
    logic               sat_inc;
    logic               start, abort_win, close_win;

    pulse_edge_filter #(
        .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_filter (
        .clk      (clk),
        .clr      (clr),
        .pulse_in (pulse_in),
        .edge_acc (edge_acc)
    );

    // Saturating increment of the running count, including this cycle's edge.
    always_comb begin
        live_inc = live_q;
        sat_inc  = sat;
        if (edge_acc) begin
            if (live_q == '1) begin
                sat_inc = 1'b1;
            end else begin
                live_inc = live_q + 1'b1;
            end
        end
    end

    // Next-state and window control decode.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        abort_win = 1'b0;
        close_win = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enb) begin
                    state_nxt = COUNT;
                    start     = 1'b1;
                end
            end
            COUNT: begin
                busy = 1'b1;
                if (!enb) begin
                    state_nxt = IDLE;
                    abort_win = 1'b1;
                end else if (win_cnt == WIN_LAST) begin
                    close_win = 1'b1;
                    state_nxt = (ONESHOT != 0) ? HOLD : COUNT;
                end
            end
            HOLD: begin
                if (!enb) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Window counter, running count and published result registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            win_cnt    <= '0;
            live_q     <= '0;
            sat        <= 1'b0;
            rate_q     <= '0;
            rate_ovf   <= 1'b0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (start || abort_win) begin
                win_cnt <= '0;
                live_q  <= '0;
                sat     <= 1'b0;
            end else if (close_win) begin
                rate_q     <= live_inc;
                rate_ovf   <= sat_inc;
                rate_valid <= 1'b1;
                win_cnt    <= '0;
                live_q     <= '0;
                sat        <= 1'b0;
            end else if (state == COUNT) begin
                win_cnt <= win_cnt + 1'b1;
                live_q  <= live_inc;
                sat     <= sat_inc;
            end
        end
    end

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Bench for pulse_rate_counter: three instances (continuous 4-bit,
// continuous 2-bit, one-shot 4-bit) share one stimulus stream and are
// compared every cycle against a timeline-based reference model.
module tb_pulse_rate_counter;

    localparam int W = 16;
    localparam int R = 3;

    logic clk;
    logic clr, enb, pulse_in;

    logic [3:0] a_live, a_rate;
    logic       a_valid, a_ovf, a_busy;
    logic [1:0] b_live, b_rate;
    logic       b_valid, b_ovf, b_busy;
    logic [3:0] c_live, c_rate;
    logic       c_valid, c_ovf, c_busy;

    pulse_rate_counter #(.CNT_W(4), .WIN_CYCLES(W), .REFRACT_CYCLES(R), .ONESHOT(0)) u_a (
        .clk(clk), .clr(clr), .enb(enb), .pulse_in(pulse_in),
        .live_q(a_live), .rate_q(a_rate), .rate_valid(a_valid), .rate_ovf(a_ovf), .busy(a_busy));

    pulse_rate_counter #(.CNT_W(2), .WIN_CYCLES(W), .REFRACT_CYCLES(R), .ONESHOT(0)) u_b (
        .clk(clk), .clr(clr), .enb(enb), .pulse_in(pulse_in),
        .live_q(b_live), .rate_q(b_rate), .rate_valid(b_valid), .rate_ovf(b_ovf), .busy(b_busy));

    pulse_rate_counter #(.CNT_W(4), .WIN_CYCLES(W), .REFRACT_CYCLES(R), .ONESHOT(1)) u_c (
        .clk(clk), .clr(clr), .enb(enb), .pulse_in(pulse_in),
        .live_q(c_live), .rate_q(c_rate), .rate_valid(c_valid), .rate_ovf(c_ovf), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs gathered per instance, zero-extended to a common width.
    logic [7:0] o_live[3], o_rate[3];
    logic       o_valid[3], o_ovf[3], o_busy[3];
    always_comb begin
        o_live[0] = {4'b0, a_live}; o_rate[0] = {4'b0, a_rate};
        o_live[1] = {6'b0, b_live}; o_rate[1] = {6'b0, b_rate};
        o_live[2] = {4'b0, c_live}; o_rate[2] = {4'b0, c_rate};
        o_valid[0] = a_valid; o_ovf[0] = a_ovf; o_busy[0] = a_busy;
        o_valid[1] = b_valid; o_ovf[1] = b_ovf; o_busy[1] = b_busy;
        o_valid[2] = c_valid; o_ovf[2] = c_ovf; o_busy[2] = c_busy;
    end

    int passes = 0;
    int total  = 0;

    // Reference model: a timeline of sampled pulse levels, time of last
    // accepted beat, and per instance a window start time and a raw
    // (unbounded) beat count that is clamped only when observed.
    int    cw[3]   = '{4, 2, 4};
    int    os[3]   = '{0, 0, 1};
    int    mode[3];          // 0 idle, 1 measuring, 2 waiting for enb low
    int    cnt[3];
    longint wstart[3];
    int    e_live[3], e_rate[3], e_ovf[3], e_valid[3], e_busy[3];
    longint n = 0;
    longint last_acc = -1000;
    bit    samp[longint];

    function automatic bit smp(input longint k);
        if (samp.exists(k)) return samp[k];
        return 1'b0;
    endfunction

    task automatic model_step();
        bit acc;
        int maxv;
        n++;
        acc = 1'b0;
        if (clr) begin
            samp[n] = 1'b0; samp[n-1] = 1'b0; samp[n-2] = 1'b0;
            last_acc = -1000;
        end else begin
            samp[n] = pulse_in;
            // a level change sampled at clock k is counted at clock k+2
            acc = smp(n-2) && !smp(n-3) && ((n - last_acc) > R);
            if (acc) last_acc = n;
        end
        for (int i = 0; i < 3; i++) begin
            maxv = (1 << cw[i]) - 1;
            e_valid[i] = 0;
            if (clr) begin
                mode[i] = 0; cnt[i] = 0; e_rate[i] = 0; e_ovf[i] = 0;
            end else if (mode[i] == 0) begin
                if (enb) begin mode[i] = 1; cnt[i] = 0; wstart[i] = n; end
            end else if (mode[i] == 1) begin
                if (!enb) begin
                    mode[i] = 0; cnt[i] = 0;
                end else begin
                    if (acc) cnt[i]++;
                    if (n - wstart[i] == W) begin
                        e_rate[i]  = (cnt[i] > maxv) ? maxv : cnt[i];
                        e_ovf[i]   = (cnt[i] > maxv) ? 1 : 0;
                        e_valid[i] = 1;
                        cnt[i]     = 0;
                        wstart[i]  = n;
                        if (os[i] != 0) mode[i] = 2;
                    end
                end
            end else begin
                if (!enb) mode[i] = 0;
            end
            e_live[i] = (cnt[i] > maxv) ? maxv : cnt[i];
            e_busy[i] = (mode[i] == 1) ? 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("live%0d@%0d", i, n),  o_live[i],          8'(e_live[i]));
            chk($sformatf("rate%0d@%0d", i, n),  o_rate[i],          8'(e_rate[i]));
            chk($sformatf("valid%0d@%0d", i, n), {7'b0, o_valid[i]}, 8'(e_valid[i]));
            chk($sformatf("ovf%0d@%0d", i, n),   {7'b0, o_ovf[i]},   8'(e_ovf[i]));
            chk($sformatf("busy%0d@%0d", i, n),  {7'b0, o_busy[i]},  8'(e_busy[i]));
        end
    endtask

    // Apply inputs, advance one clock, then compare on the falling edge.
    task automatic cycle(input logic c, input logic e, input logic p);
        clr = c; enb = e; pulse_in = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    int c_valids;

    initial begin
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0; cnt[i] = 0; wstart[i] = 0;
            e_live[i] = 0; e_rate[i] = 0; e_ovf[i] = 0; e_valid[i] = 0; e_busy[i] = 0;
        end
        clr = 1'b1; enb = 1'b0; pulse_in = 1'b0;

        // clr held with pulse toggling: everything stays zero
        for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1, 1'(j % 2));
        chk("clr_rateA", o_rate[0], 8'd0);
        chk("clr_busyA", {7'b0, o_busy[0]}, 8'd0);

        // four beats spaced 4 cycles; 2-bit instance saturates
        cycle(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 16; j++) cycle(1'b0, 1'b1, 1'((j % 4 == 1) && (j <= 13)));
        chk("p1_rateA",  o_rate[0], 8'd4);
        chk("p1_validA", {7'b0, o_valid[0]}, 8'd1);
        chk("p1_rateB",  o_rate[1], 8'd3);
        chk("p1_ovfB",   {7'b0, o_ovf[1]}, 8'd1);
        chk("p1_busyC",  {7'b0, o_busy[2]}, 8'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("p1_abort_rateA", o_rate[0], 8'd4);

        // beats every 2 cycles (lockout drops every other) then a long high level
        cycle(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 16; j++)
            cycle(1'b0, 1'b1, 1'(((j <= 8) && (j % 2 == 1)) || ((j >= 10) && (j <= 15))));
        chk("p2_rateA", o_rate[0], 8'd3);
        chk("p2_rateB", o_rate[1], 8'd3);
        chk("p2_ovfB",  {7'b0, o_ovf[1]}, 8'd0);
        cycle(1'b0, 1'b0, 1'b0);

        // enb dropped mid-window
        cycle(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 9; j++) cycle(1'b0, 1'b1, 1'((j == 1) || (j == 5)));
        chk("p3_liveA", o_live[0], 8'd2);
        cycle(1'b0, 1'b0, 1'b0);
        chk("p3_liveA0", o_live[0], 8'd0);
        chk("p3_rateA",  o_rate[0], 8'd3);

        // clr mid-window
        cycle(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 9; j++) cycle(1'b0, 1'b1, 1'(j == 1));
        cycle(1'b1, 1'b1, 1'b0);
        chk("p3_clr_rateA", o_rate[0], 8'd0);
        cycle(1'b0, 1'b0, 1'b0);

        // edge landing in the final window cycle, then back-to-back windows
        c_valids = 0;
        cycle(1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 40; j++) begin
            cycle(1'b0, 1'b1, 1'(j == 14));
            c_valids += int'(o_valid[2]);
            if (j == 16) begin
                chk("p4_rateA",  o_rate[0], 8'd1);
                chk("p4_liveA",  o_live[0], 8'd0);
            end
            if (j == 17) chk("p4_busyA", {7'b0, o_busy[0]}, 8'd1);
            if (j == 32) begin
                chk("p4_valid2A", {7'b0, o_valid[0]}, 8'd1);
                chk("p4_rate2A",  o_rate[0], 8'd0);
            end
        end
        chk("p4_oneshot_count", 8'(c_valids), 8'd1);
        chk("p4_rateC", o_rate[2], 8'd1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("p4_rearmC", {7'b0, o_busy[2]}, 8'd1);

        // randomized traffic
        for (int j = 0; j < 800; j++)
            cycle(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 29) != 0),
                  1'($urandom_range(0, 3) == 0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
